// File: rtl/prs_ber_checker.sv
// prs_ber_checker: self-synchronising PRS bit-error checker.
// A local LFSR is loaded from the received decoded bit stream. Once enough
// consecutive predictions match, it free-runs and the checker counts errors
// per programmable window. Lock is dropped when a window's error count
// reaches the loss threshold.
//
// Handshake: i_vld/i_sym form a valid-only stream with no backpressure. A bit
// is consumed on every posedge clk where i_vld=1. Gaps of any length are
// allowed, and state and counters hold while i_vld=0. o_err_vld is a one-cycle
// strobe qualifying o_err_cnt, and o_err_cnt holds its value between strobes.
module prs_ber_checker #(
    parameter int PRS_LEN = 15,
    parameter int TAP_A   = 15,
    parameter int TAP_B   = 14,
    parameter int WIN_W   = 16,
    parameter int ERR_W   = 16
) (
    input  logic             clk,
    input  logic             nRESET,
    input  logic             i_vld,
    input  logic             i_sym,
    input  logic [WIN_W-1:0] i_win_len,
    input  logic [ERR_W-1:0] i_loss_thr,
    input  logic [7:0]       i_lock_len,
    output logic             o_locked,
    output logic             o_err_vld,
    output logic [ERR_W-1:0] o_err_cnt,
    output logic [7:0]       o_loss_cnt,
    output logic [1:0]       o_dbg_state
);

    localparam int LCNT_W = $clog2(PRS_LEN + 1);

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t             state;
    logic [PRS_LEN-1:0] lfsr;
    logic [LCNT_W-1:0]  load_cnt;
    logic [7:0]         match_cnt;
    logic [WIN_W-1:0]   bit_cnt;
    logic [ERR_W-1:0]   win_err;
    logic [WIN_W-1:0]   win_len_q;

    logic               pred;
    logic               err_bit;
    logic               lfsr_zero;
    logic [7:0]         lock_target;
    logic [8:0]         match_next;
    logic [ERR_W-1:0]   win_err_next;
    logic [WIN_W-1:0]   bit_next;
    logic               win_end;

    assign o_dbg_state = state;

    // Prediction, error bit and next-value terms shared by the state machine
    always_comb begin
        pred         = lfsr[TAP_A-1] ^ lfsr[TAP_B-1];
        err_bit      = i_sym ^ pred;
        lfsr_zero    = (lfsr == '0);
        lock_target  = (i_lock_len == 8'd0) ? 8'd1 : i_lock_len;
        match_next   = {1'b0, match_cnt} + 9'd1;
        win_err_next = (&win_err) ? win_err : (win_err + ERR_W'(err_bit));
        bit_next     = bit_cnt + WIN_W'(1);
        win_end      = (win_len_q != '0) && (bit_next == win_len_q);
    end

    // Alignment state machine, window counters and registered outputs
    always_ff @(posedge clk) begin
        if (!nRESET) begin
            state      <= ST_LOAD;
            lfsr       <= '0;
            load_cnt   <= '0;
            match_cnt  <= '0;
            bit_cnt    <= '0;
            win_err    <= '0;
            win_len_q  <= '0;
            o_locked   <= 1'b0;
            o_err_vld  <= 1'b0;
            o_err_cnt  <= '0;
            o_loss_cnt <= '0;
        end else begin
            o_err_vld <= 1'b0;
            if (i_vld) begin
                case (state)
                    ST_LOAD: begin
                        lfsr <= {lfsr[PRS_LEN-2:0], i_sym};
                        if (load_cnt == LCNT_W'(PRS_LEN - 1)) begin
                            state     <= ST_VERIFY;
                            load_cnt  <= '0;
                            match_cnt <= '0;
                        end else begin
                            load_cnt <= load_cnt + LCNT_W'(1);
                        end
                    end
                    ST_VERIFY: begin
                        lfsr <= {lfsr[PRS_LEN-2:0], i_sym};
                        if (lfsr_zero || err_bit) begin
                            // The offending bit is already shifted in, so it
                            // counts as the first bit of the reload.
                            state    <= ST_LOAD;
                            load_cnt <= LCNT_W'(1);
                        end else if (match_next >= {1'b0, lock_target}) begin
                            state     <= ST_LOCKED;
                            o_locked  <= 1'b1;
                            bit_cnt   <= '0;
                            win_err   <= '0;
                            win_len_q <= i_win_len;
                        end else begin
                            match_cnt <= match_next[7:0];
                        end
                    end
                    ST_LOCKED: begin
                        lfsr <= {lfsr[PRS_LEN-2:0], pred};
                        if (win_len_q == '0) begin
                            // Windowing off: keep re-sampling the length so
                            // that enabling it starts a window on the next bit.
                            bit_cnt   <= '0;
                            win_err   <= '0;
                            win_len_q <= i_win_len;
                        end else if (win_end) begin
                            o_err_cnt <= win_err_next;
                            o_err_vld <= 1'b1;
                            bit_cnt   <= '0;
                            win_err   <= '0;
                            win_len_q <= i_win_len;
                            if (win_err_next >= i_loss_thr) begin
                                state    <= ST_LOAD;
                                load_cnt <= '0;
                                o_locked <= 1'b0;
                                if (o_loss_cnt != 8'hFF) begin
                                    o_loss_cnt <= o_loss_cnt + 8'd1;
                                end
                            end
                        end else begin
                            bit_cnt <= bit_next;
                            win_err <= win_err_next;
                        end
                    end
                    default: begin
                        state    <= ST_LOAD;
                        load_cnt <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_prs_ber_checker.sv
// Directed testbench for prs_ber_checker: lock latency, windowed error
// counts, lock loss and relock, all-zero input, windowing disabled,
// gapped valid stream and mid-window reset.
module tb_prs_ber_checker;

    localparam int WIN_W = 16;
    localparam int ERR_W = 16;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             nRESET = 1'b0;
    logic             i_vld = 1'b0;
    logic             i_sym = 1'b0;
    logic [WIN_W-1:0] i_win_len = '0;
    logic [ERR_W-1:0] i_loss_thr = '0;
    logic [7:0]       i_lock_len = '0;
    logic             o_locked;
    logic             o_err_vld;
    logic [ERR_W-1:0] o_err_cnt;
    logic [7:0]       o_loss_cnt;
    logic [1:0]       o_dbg_state;

    prs_ber_checker #(
        .PRS_LEN(15), .TAP_A(15), .TAP_B(14), .WIN_W(WIN_W), .ERR_W(ERR_W)
    ) dut (
        .clk        (clk),
        .nRESET     (nRESET),
        .i_vld      (i_vld),
        .i_sym      (i_sym),
        .i_win_len  (i_win_len),
        .i_loss_thr (i_loss_thr),
        .i_lock_len (i_lock_len),
        .o_locked   (o_locked),
        .o_err_vld  (o_err_vld),
        .o_err_cnt  (o_err_cnt),
        .o_loss_cnt (o_loss_cnt),
        .o_dbg_state(o_dbg_state)
    );

    // ---------------- scoreboard ----------------
    logic [ERR_W-1:0] exp_q[$];
    int n_checks = 0;
    int n_errors = 0;
    int pulse_cnt = 0;
    int stray_pulse = 0;
    bit saw_lock = 1'b0;
    logic [14:0] gen = 15'h0001;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Reference PRS: x^15+x^14+1, newest bit at index 0
    task automatic next_prs(output logic b);
        b = gen[14] ^ gen[13];
        gen = {gen[13:0], b};
    endtask

    // ---------------- driver tasks ----------------
    task automatic reset_cycles(input int n);
        nRESET = 1'b0;
        i_vld = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        check_val("rst_locked", o_locked, 0);
        check_val("rst_err_vld", o_err_vld, 0);
        check_val("rst_err_cnt", o_err_cnt, 0);
        check_val("rst_loss_cnt", o_loss_cnt, 0);
        check_val("rst_state", o_dbg_state, 0);
        nRESET = 1'b1;
        exp_q.delete();
    endtask

    // One valid bit, then 'gap' idle cycles; pulses are scored as seen.
    task automatic send_bit(input logic b, input int gap);
        i_vld = 1'b1;
        i_sym = b;
        @(posedge clk);
        #1;
        i_vld = 1'b0;
        if (o_locked) saw_lock = 1'b1;
        if (o_err_vld) begin
            pulse_cnt++;
            check_val("pulse_expected", (exp_q.size() != 0), 1);
            if (exp_q.size() != 0) check_val("win_err_cnt", o_err_cnt, exp_q.pop_front());
        end
        for (int g = 0; g < gap; g++) begin
            @(posedge clk);
            #1;
            if (o_err_vld) stray_pulse++;
        end
    endtask

    // n PRS bits; flip_per>0 flips every flip_per-th bit, inv inverts all,
    // zero sends zeros instead of the PRS.
    task automatic send_n(input int n, input int flip_per, input bit inv, input bit zero, input int gap);
        logic b;
        for (int k = 0; k < n; k++) begin
            next_prs(b);
            if (zero) b = 1'b0;
            if (inv) b = ~b;
            if (flip_per > 0 && (k % flip_per) == flip_per - 1) b = ~b;
            send_bit(b, gap);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    int base;
    int lock_bits;

    initial begin
        // ---- reset state ----
        reset_cycles(2);

        // ---- clean continuous PRS: lock after 47 bits ----
        i_lock_len = 8'd32;
        i_win_len  = 16'd1000;
        i_loss_thr = 16'd100;
        send_n(46, 0, 0, 0, 0);
        check_val("no_lock_46", o_locked, 0);
        send_n(1, 0, 0, 0, 0);
        check_val("lock_47", o_locked, 1);
        check_val("state_locked", o_dbg_state, 2);
        exp_q.push_back(16'd0);
        send_n(999, 0, 0, 0, 0);
        check_val("no_early_pulse", exp_q.size(), 1);
        send_n(1, 0, 0, 0, 0);
        check_val("pulse_at_1000", o_err_vld, 1);
        check_val("clean_win_scored", exp_q.size(), 0);
        send_n(1, 0, 0, 0, 0);
        check_val("pulse_one_cycle", o_err_vld, 0);
        check_val("clean_loss", o_loss_cnt, 0);

        // ---- locked, flip every 100th bit: 10 errors per window ----
        // One clean bit of this window is already in; 999 more with
        // flips at window positions 100..1000, then one full window.
        exp_q.push_back(16'd10);
        exp_q.push_back(16'd10);
        begin : flip_phase
            logic b;
            for (int k = 0; k < 999; k++) begin
                next_prs(b);
                if (((k + 2) % 100) == 0) b = ~b;
                send_bit(b, 0);
            end
        end
        send_n(1000, 100, 0, 0, 0);
        check_val("flip_wins_scored", exp_q.size(), 0);
        check_val("flip_err_cnt", o_err_cnt, 10);
        check_val("flip_still_locked", o_locked, 1);
        check_val("flip_loss", o_loss_cnt, 0);

        // ---- inverted stream: 1000 errors, lock drops with the pulse ----
        exp_q.push_back(16'd1000);
        send_n(1000, 0, 1, 0, 0);
        check_val("inv_pulse", o_err_vld, 1);
        check_val("inv_err_cnt", o_err_cnt, 1000);
        check_val("inv_unlocked", o_locked, 0);
        check_val("inv_loss_cnt", o_loss_cnt, 1);
        check_val("inv_state_load", o_dbg_state, 0);
        saw_lock = 1'b0;
        base = pulse_cnt;
        send_n(1000, 0, 1, 0, 0);
        check_val("inv_no_relock", saw_lock, 0);
        check_val("inv_no_pulse", pulse_cnt - base, 0);

        // ---- restore clean PRS: relock within 47+1000 bits ----
        lock_bits = 0;
        while (!o_locked && lock_bits < 1047) begin
            send_n(1, 0, 0, 0, 0);
            lock_bits++;
        end
        check_val("relock", o_locked, 1);
        check_val("relock_in_budget", (lock_bits <= 1047), 1);
        check_val("relock_loss_cnt", o_loss_cnt, 1);

        // ---- 1-cycle reset mid-window while locked ----
        send_n(500, 0, 0, 0, 0);
        reset_cycles(1);
        send_n(46, 0, 0, 0, 0);
        check_val("post_rst_no_lock_46", o_locked, 0);
        send_n(1, 0, 0, 0, 0);
        check_val("post_rst_lock_47", o_locked, 1);
        exp_q.push_back(16'd0);
        send_n(1000, 0, 0, 0, 0);
        check_val("post_rst_win_scored", exp_q.size(), 0);
        check_val("post_rst_loss", o_loss_cnt, 0);

        // ---- all-zero input: never locks, never pulses ----
        reset_cycles(1);
        saw_lock = 1'b0;
        base = pulse_cnt;
        send_n(10000, 0, 0, 1, 0);
        check_val("zero_never_locked", saw_lock, 0);
        check_val("zero_no_pulse", pulse_cnt - base, 0);

        // ---- lock_len=0 acts as 1; win_len=0 disables windows ----
        reset_cycles(1);
        i_lock_len = 8'd0;
        i_win_len  = 16'd0;
        send_n(15, 0, 0, 0, 0);
        check_val("ll0_no_lock_15", o_locked, 0);
        send_n(1, 0, 0, 0, 0);
        check_val("ll0_lock_16", o_locked, 1);
        base = pulse_cnt;
        send_n(2000, 0, 1, 0, 0);
        check_val("win0_no_pulse", pulse_cnt - base, 0);
        check_val("win0_keeps_lock", o_locked, 1);
        check_val("win0_err_cnt_held", o_err_cnt, 0);

        // ---- gapped valid (1-in-64), mid-window length change ----
        reset_cycles(1);
        i_lock_len  = 8'd32;
        i_win_len   = 16'd100;
        stray_pulse = 0;
        send_n(46, 0, 0, 0, 63);
        check_val("gap_no_lock_46", o_locked, 0);
        send_n(1, 0, 0, 0, 63);
        check_val("gap_lock_47", o_locked, 1);
        exp_q.push_back(16'd0);
        send_n(50, 0, 0, 0, 63);
        i_win_len = 16'd50;
        send_n(50, 0, 0, 0, 63);
        check_val("gap_win100_scored", exp_q.size(), 0);
        exp_q.push_back(16'd5);
        send_n(50, 10, 0, 0, 63);
        check_val("gap_win50_scored", exp_q.size(), 0);
        check_val("gap_err_cnt", o_err_cnt, 5);
        check_val("gap_locked", o_locked, 1);
        check_val("no_pulse_in_gap", stray_pulse, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
